// File: rtl/tx_dsp_pkg.sv
// Shared constants and helpers for the Tx upsampling chain:
// halfband taps, CIC defaults and the output round/saturate step.
package tx_dsp_pkg;

  localparam int HB_TAPS  = 7;
  localparam int HB_COEF [HB_TAPS] = '{-1, 0, 9, 16, 9, 0, -1};
  localparam int HB_SHIFT = 4;
  localparam int HB_RND   = 1 <<< (HB_SHIFT - 1);

  localparam int CIC_N_DEF = 3;
  localparam int CIC_R_DEF = 4;
  localparam int CIC_W_DEF = 17;

  // Round half up by 2^shift, then clamp to a signed out_w-bit range.
  function automatic int round_sat(input int v, input int shift, input int out_w);
    int r;
    int hi;
    int lo;
    r  = (v + (1 <<< (shift - 1))) >>> shift;
    hi = (1 <<< (out_w - 1)) - 1;
    lo = -(1 <<< (out_w - 1));
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/cic_interp_core.sv
// CIC interpolator x CIC_R: combs at the halfband rate, zero-stuffing,
// integrators at clk_8, then gain removal with rounding and saturation.
module cic_interp_core
  import tx_dsp_pkg::*;
#(
  parameter int HB_W  = 11,
  parameter int OUT_W = 12,
  parameter int CIC_N = CIC_N_DEF,
  parameter int CIC_R = CIC_R_DEF,
  parameter int CIC_W = CIC_W_DEF,
  parameter int PH_W  = 3
) (
  input  logic                    clk_8,
  input  logic                    rst_n,
  input  logic [PH_W-1:0]         ph,
  input  logic signed [HB_W-1:0]  hb_in,
  output logic signed [OUT_W-1:0] out_data
);

  localparam int GAIN_SHIFT = (CIC_N - 1) * $clog2(CIC_R);
  localparam logic [PH_W-1:0] PH_COMB_A = PH_W'(1);
  localparam logic [PH_W-1:0] PH_COMB_B = PH_W'(CIC_R + 1);
  localparam logic [PH_W-1:0] PH_U_A    = PH_W'(2);
  localparam logic [PH_W-1:0] PH_U_B    = PH_W'(CIC_R + 2);

  logic signed [CIC_W-1:0] comb_prev [CIC_N];
  logic signed [CIC_W-1:0] comb_in_next [CIC_N];
  logic signed [CIC_W-1:0] comb_next;
  logic signed [CIC_W-1:0] comb_out;
  logic signed [CIC_W-1:0] integ [CIC_N];
  logic signed [CIC_W-1:0] u;
  logic                    comb_en;
  logic                    u_en;

  always_comb begin
    logic signed [CIC_W-1:0] d;
    comb_en = (ph == PH_COMB_A) || (ph == PH_COMB_B);
    u_en    = (ph == PH_U_A) || (ph == PH_U_B);
    d       = CIC_W'(hb_in);
    for (int k = 0; k < CIC_N; k++) begin
      comb_in_next[k] = d;
      d = d - comb_prev[k];
    end
    comb_next = d;
    // Zero-stuffing: the comb result appears for one cycle out of CIC_R.
    u = u_en ? comb_out : '0;
  end

  always_ff @(posedge clk_8 or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CIC_N; k++) begin
        comb_prev[k] <= '0;
        integ[k]     <= '0;
      end
      comb_out <= '0;
      out_data <= '0;
    end else begin
      if (comb_en) begin
        for (int k = 0; k < CIC_N; k++) comb_prev[k] <= comb_in_next[k];
        comb_out <= comb_next;
      end
      // Integrators wrap modulo 2^CIC_W; the combs undo the wrap exactly.
      integ[0] <= integ[0] + u;
      for (int k = 1; k < CIC_N; k++) integ[k] <= integ[k] + integ[k-1];
      out_data <= OUT_W'(round_sat(int'(integ[CIC_N-1]), GAIN_SHIFT, OUT_W));
    end
  end

endmodule

// File: rtl/interpolation_tx.sv
// Tx x8 upsampler: phase counter, input delay line, polyphase halfband x2,
// followed by the CIC x4 core. Everything runs on clk_8.
module interpolation_tx
  import tx_dsp_pkg::*;
#(
  parameter int IN_W  = 10,
  parameter int OUT_W = 12,
  parameter int CIC_N = CIC_N_DEF,
  parameter int CIC_R = CIC_R_DEF,
  parameter int CIC_W = CIC_W_DEF
) (
  input  logic                    rst_n,
  input  logic                    clk_8,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  output logic                    underflow
);

  localparam int PERIOD = 2 * CIC_R;
  localparam int PH_W   = $clog2(PERIOD);
  localparam int HB_W   = IN_W + 1;
  // Accept edge -> x2 (two periods) -> branch A -> CIC pipeline -> out_data.
  localparam int VALID_LAT = 2 * PERIOD + 1 + CIC_N + 2;
  localparam int LAT_W     = $clog2(VALID_LAT + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0] PH_A    = '0;
  localparam logic [PH_W-1:0] PH_B    = PH_W'(CIC_R);

  logic [PH_W-1:0]        ph;
  logic signed [IN_W-1:0] x [4];
  logic signed [HB_W-1:0] hb_out;
  logic signed [HB_W-1:0] hb_a;
  logic signed [HB_W-1:0] hb_b;
  logic                   accept_slot;
  logic                   started;
  logic [LAT_W-1:0]       lat_cnt;

  assign accept_slot = (ph == PH_LAST);
  assign in_ready    = accept_slot;

  always_comb begin
    hb_a = HB_W'((HB_COEF[3] * int'(x[2]) + HB_RND) >>> HB_SHIFT);
    hb_b = HB_W'((HB_COEF[0] * int'(x[0]) + HB_COEF[2] * int'(x[1]) +
                  HB_COEF[4] * int'(x[2]) + HB_COEF[6] * int'(x[3]) + HB_RND) >>> HB_SHIFT);
  end

  always_ff @(posedge clk_8 or negedge rst_n) begin
    if (!rst_n) begin
      ph     <= '0;
      hb_out <= '0;
      for (int k = 0; k < 4; k++) x[k] <= '0;
    end else begin
      ph <= accept_slot ? '0 : ph + 1'b1;
      if (accept_slot) begin
        for (int k = 3; k > 0; k--) x[k] <= x[k-1];
        // A missing sample becomes a zero so the output rate never stalls.
        x[0] <= in_valid ? in_data : '0;
      end
      if (ph == PH_A) hb_out <= hb_a;
      else if (ph == PH_B) hb_out <= hb_b;
    end
  end

  always_ff @(posedge clk_8 or negedge rst_n) begin
    if (!rst_n) begin
      started   <= 1'b0;
      lat_cnt   <= '0;
      out_valid <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (accept_slot && !in_valid) underflow <= 1'b1;
      if (!started) begin
        if (accept_slot && in_valid) begin
          started <= 1'b1;
          lat_cnt <= '0;
        end
      end else if (!out_valid) begin
        lat_cnt <= lat_cnt + 1'b1;
        if (lat_cnt == LAT_W'(VALID_LAT)) out_valid <= 1'b1;
      end
    end
  end

  cic_interp_core #(
    .HB_W (HB_W),
    .OUT_W(OUT_W),
    .CIC_N(CIC_N),
    .CIC_R(CIC_R),
    .CIC_W(CIC_W),
    .PH_W (PH_W)
  ) u_cic (
    .clk_8   (clk_8),
    .rst_n   (rst_n),
    .ph      (ph),
    .hb_in   (hb_out),
    .out_data(out_data)
  );

endmodule

// File: tb/tb_interpolation_tx.sv
// Bench for interpolation_tx: the output is predicted by convolving the
// zero-stuffed halfband stream with the equivalent CIC impulse response.
module tb_interpolation_tx;

  localparam int IN_W  = 10;
  localparam int OUT_W = 12;
  localparam int H [10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

  logic                    clk_8 = 1'b0;
  logic                    rst_n = 1'b0;
  logic signed [IN_W-1:0]  in_data = '0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    underflow;

  int n_checks = 0;
  int n_fail   = 0;
  int t;
  int ea;
  bit uf_m;
  int xm [4];
  int vq [$];
  int sat_hits = 0;
  int hb_seen_a;
  int hb_seen_b;
  int out_sum;

  typedef struct {
    bit vld;
    int data;
    int exp_a;
    int exp_b;
  } vec_t;
  vec_t imp_tbl [9];

  always #5 clk_8 = ~clk_8;

  interpolation_tx dut (
    .rst_n    (rst_n),
    .clk_8    (clk_8),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .underflow(underflow)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t  = 0;
    ea = 0;
    uf_m = 1'b0;
    for (int i = 0; i < 4; i++) xm[i] = 0;
    vq.delete();
    repeat (16) vq.push_back(0);
  endtask

  // vq[j] holds the halfband value written j edges ago (0 on other edges).
  function automatic int conv_out();
    int y = 0;
    for (int k = 0; k < 10; k++) y += H[k] * vq[5 + k];
    return (y + 8) >>> 4;
  endfunction

  task automatic cycle(input bit vld, input int d);
    int hb;
    int r;
    if (t % 8 == 7) begin
      in_valid = vld;
      in_data  = IN_W'(d);
    end else begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = IN_W'($urandom);
    end
    @(posedge clk_8);
    t++;
    hb = 0;
    case ((t - 1) % 8)
      7: begin
        xm[3] = xm[2]; xm[2] = xm[1]; xm[1] = xm[0];
        xm[0] = vld ? d : 0;
        if (!vld) uf_m = 1'b1;
        else if (ea == 0) ea = t;
      end
      0: hb = xm[2];
      4: hb = (-xm[0] + 9 * xm[1] + 9 * xm[2] - xm[3] + 8) >>> 4;
      default: ;
    endcase
    vq.push_front(hb);
    void'(vq.pop_back());
    r = conv_out();
    if (r > 2047) begin r = 2047; sat_hits++; end
    else if (r < -2048) begin r = -2048; sat_hits++; end
    @(negedge clk_8);
    if (t % 8 == 1) hb_seen_a = int'(dut.hb_out);
    if (t % 8 == 5) hb_seen_b = int'(dut.hb_out);
    out_sum += int'(out_data);
    check("out_data", int'(out_data), r);
    check("out_valid", int'(out_valid), int'(ea != 0 && t >= ea + 23));
    check("underflow", int'(underflow), int'(uf_m));
    check("in_ready", int'(in_ready), int'(t % 8 == 7));
  endtask

  task automatic period(input bit vld, input int d);
    repeat (8) cycle(vld, d);
  endtask

  // Asserts reset while ph==4 and checks the asynchronous clear.
  task automatic mid_reset(input int d);
    while (t % 8 != 4) cycle(1'b1, d);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_underflow", int'(underflow), 0);
    check("rst_in_ready", int'(in_ready), 0);
    repeat (2) @(posedge clk_8);
    @(negedge clk_8);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    imp_tbl[0] = '{1'b1, 0,   0,   0};
    imp_tbl[1] = '{1'b1, 0,   0,   0};
    imp_tbl[2] = '{1'b1, 160, 0,   0};
    imp_tbl[3] = '{1'b1, 0,   0,   -10};
    imp_tbl[4] = '{1'b1, 0,   0,   90};
    imp_tbl[5] = '{1'b1, 0,   160, 90};
    imp_tbl[6] = '{1'b1, 0,   0,   -10};
    imp_tbl[7] = '{1'b1, 0,   0,   0};
    imp_tbl[8] = '{1'b1, 0,   0,   0};

    // Power-on reset.
    rst_n = 1'b0;
    repeat (20) @(posedge clk_8);
    @(negedge clk_8);
    check("por_out_data", int'(out_data), 0);
    check("por_out_valid", int'(out_valid), 0);
    check("por_underflow", int'(underflow), 0);
    check("por_in_ready", int'(in_ready), 0);
    rst_n = 1'b1;
    model_reset();

    // DC, then a reset in the middle of the stream, then DC again.
    repeat (40) period(1'b1, 100);
    check("dc_level", int'(out_data), 100);
    mid_reset(100);
    repeat (40) period(1'b1, 100);
    check("dc_level_after_reset", int'(out_data), 100);
    mid_reset(100);

    // Impulse response from the table, then let the tail drain.
    out_sum = 0;
    for (int i = 0; i < 9; i++) begin
      period(imp_tbl[i].vld, imp_tbl[i].data);
      check("hb_branch_a", hb_seen_a, imp_tbl[i].exp_a);
      check("hb_branch_b", hb_seen_b, imp_tbl[i].exp_b);
    end
    repeat (3) period(1'b1, 0);
    check("impulse_sum_in_range", int'(out_sum >= 1264 && out_sum <= 1296), 1);
    check("impulse_settled", int'(out_data), 0);

    // Full-scale alternation, then random data with one dropped slot.
    for (int i = 0; i < 20; i++) period(1'b1, (i % 2 == 0) ? 511 : -512);
    for (int i = 0; i < 60; i++) begin
      int d;
      if (i == 30) begin
        check("underflow_before_drop", int'(underflow), 0);
        period(1'b0, 0);
        check("underflow_after_drop", int'(underflow), 1);
      end else begin
        case ($urandom_range(0, 3))
          0:       d = 511;
          1:       d = -512;
          default: d = int'($urandom_range(0, 1023)) - 512;
        endcase
        period(1'b1, d);
      end
    end
    check("underflow_sticky", int'(underflow), 1);
    $display("saturation hits predicted: %0d", sat_hits);
    mid_reset(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
